// File: rtl/alu_pkg.sv
// Shared types for the execute-stage back end: ALU op codes, branch kinds,
// the NZCV flag layout and the B.cond evaluator.
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_HS, COND_LO, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_CBZ  = 2'b10,
        BR_CBNZ = 2'b11
    } br_kind_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic cond_eval(flags_t f, cond_e c);
        logic r;
        case (c)
            COND_EQ: r = f.z;
            COND_NE: r = !f.z;
            COND_HS: r = f.c;
            COND_LO: r = !f.c;
            COND_MI: r = f.n;
            COND_PL: r = !f.n;
            COND_VS: r = f.v;
            COND_VC: r = !f.v;
            COND_HI: r = f.c & !f.z;
            COND_LS: r = !(f.c & !f.z);
            COND_GE: r = (f.n == f.v);
            COND_LT: r = (f.n != f.v);
            COND_GT: r = !f.z & (f.n == f.v);
            COND_LE: r = !(!f.z & (f.n == f.v));
            default: r = 1'b1;  // AL and NV both always pass
        endcase
        return r;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry elastic buffer (main + skid). in_ready decodes only the state
// register, so the upstream ready path never sees out_ready combinationally.
module skid_buffer
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e state_q, state_d;
    logic [W-1:0] main_q, skid_q;
    logic accept, emit;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= BUF_EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: if (accept) state_d = BUF_ONE;
            BUF_ONE: begin
                if (accept && !emit)      state_d = BUF_FULL;
                else if (!accept && emit) state_d = BUF_EMPTY;
            end
            BUF_FULL:  if (emit) state_d = BUF_ONE;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != BUF_FULL);
        out_valid = (state_q != BUF_EMPTY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state_q)
                BUF_EMPTY: if (accept) main_q <= in_data;
                BUF_ONE: begin
                    if (accept && emit) main_q <= in_data;
                    else if (accept)    skid_q <= in_data;
                end
                BUF_FULL:  if (emit) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign out_data = main_q;

endmodule

// File: rtl/alu_flag_stage.sv
// ALU back end: registers result/rd/branch outcome through a skid buffer,
// keeps the NZCV register and resolves B.cond / CBZ / CBNZ at accept.
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_negative,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    input  logic               alu_carry_out,
    input  logic [2:0]         alu_cntrl,
    input  logic               set_flags,
    input  logic [1:0]         br_kind,
    input  logic [3:0]         cond,
    input  logic [RADDR_W-1:0] rd,
    input  logic               wr_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_wr_en,
    output logic               out_br_taken,
    output logic [3:0]         flags_q
);

    localparam int PW = WIDTH + RADDR_W + 2;

    flags_t flags_r;
    logic accept, br_taken;
    logic [PW-1:0] pay_in, pay_out;

    assign accept = in_valid & in_ready;

    // B.cond reads the pre-update flags, so a flag-setter followed directly
    // by a branch sees the setter's result through flags_r.
    always_comb begin
        br_taken = 1'b0;
        case (br_kind_e'(br_kind))
            BR_COND: br_taken = cond_eval(flags_r, cond_e'(cond));
            BR_CBZ:  br_taken = alu_zero;
            BR_CBNZ: br_taken = !alu_zero;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_r <= '0;
        end else if (accept && set_flags) begin
            case (alu_cntrl)
                ALU_ADD, ALU_SUBTRACT:
                    flags_r <= '{n: alu_negative, z: alu_zero, c: alu_carry_out, v: alu_overflow};
                ALU_AND:
                    flags_r <= '{n: alu_negative, z: alu_zero, c: 1'b0, v: 1'b0};
                default: ;
            endcase
        end
    end

    assign flags_q = flags_r;
    assign pay_in  = {alu_result, rd, wr_en, br_taken};

    skid_buffer #(.W(PW)) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    assign {out_result, out_rd, out_wr_en, out_br_taken} = pay_out;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed bench for alu_flag_stage: queue-based scoreboard checked every
// negedge, plus literal expectations on the documented scenarios.
module tb_alu_flag_stage;

    logic        clk, reset_n;
    logic        in_valid, in_ready;
    logic [63:0] alu_result;
    logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic [2:0]  alu_cntrl;
    logic        set_flags;
    logic [1:0]  br_kind;
    logic [3:0]  cond;
    logic [4:0]  rd;
    logic        wr_en;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wr_en, out_br_taken;
    logic [3:0]  flags_q;

    int n_err = 0;
    int n_checks = 0;

    alu_flag_stage #(.WIDTH(64), .RADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .alu_cntrl(alu_cntrl), .set_flags(set_flags),
        .br_kind(br_kind), .cond(cond), .rd(rd), .wr_en(wr_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
        .out_br_taken(out_br_taken), .flags_q(flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wr;
        logic        tk;
    } beat_t;

    beat_t      m_q[$];
    logic [3:0] m_flags;  // {N,Z,C,V}

    function automatic logic m_cond(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] != 3'd7 && c[0]) base = !base;
        return base;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic acc, emt, tk;
        beat_t b;
        if (!reset_n) begin
            m_q.delete();
            m_flags <= 4'b0;
        end else begin
            acc = in_valid && (m_q.size() < 2);
            emt = (m_q.size() != 0) && out_ready;
            if (emt) void'(m_q.pop_front());
            if (acc) begin
                if (br_kind == 2'b01)      tk = m_cond(m_flags, cond);
                else if (br_kind == 2'b10) tk = alu_zero;
                else if (br_kind == 2'b11) tk = !alu_zero;
                else                       tk = 1'b0;
                b.res = alu_result; b.rd = rd; b.wr = wr_en; b.tk = tk;
                m_q.push_back(b);
                if (set_flags && (alu_cntrl == 3'b010 || alu_cntrl == 3'b011))
                    m_flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
                else if (set_flags && alu_cntrl == 3'b100)
                    m_flags <= {alu_negative, alu_zero, 2'b00};
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_q.size() < 2);
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("flags_q", flags_q, m_flags);
        if (m_q.size() != 0) begin
            chk("out_result", out_result, m_q[0].res);
            chk("out_rd", out_rd, m_q[0].rd);
            chk("out_wr_en", out_wr_en, m_q[0].wr);
            chk("out_br_taken", out_br_taken, m_q[0].tk);
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input logic [63:0] res, input logic [3:0] nzcv, input logic [2:0] op,
                        input logic sf, input logic [1:0] bk, input logic [3:0] cd,
                        input logic [4:0] r);
        in_valid   = 1'b1;
        alu_result = res;
        {alu_negative, alu_zero, alu_carry_out, alu_overflow} = nzcv;
        alu_cntrl  = op;
        set_flags  = sf;
        br_kind    = bk;
        cond       = cd;
        rd         = r;
        wr_en      = (bk == 2'b00);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        set_flags = 1'b0;
        br_kind = 2'b00;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        out_ready = 1'b1;
        beat(64'd0, 4'b0000, 3'b000, 1'b0, 2'b00, 4'd0, 5'd0);
        idle();
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst flags_q", flags_q, 4'b0000);
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst out_result", out_result, 64'd0);
        chk("rst out_br_taken", out_br_taken, 1'b0);
        step();
        reset_n = 1'b1;
        step();

        // ADDS setting N and V, then B.GE and B.VS back to back
        beat(64'h8000_0000_0000_0000, 4'b1001, 3'b010, 1'b1, 2'b00, 4'd0, 5'd1);
        step();
        chk("adds out_valid", out_valid, 1'b1);
        chk("adds out_result", out_result, 64'h8000_0000_0000_0000);
        chk("adds flags", flags_q, 4'b1001);
        beat(64'd0, 4'b0100, 3'b000, 1'b0, 2'b01, 4'b1010, 5'd0);
        step();
        chk("b.ge taken", out_br_taken, 1'b1);
        beat(64'd0, 4'b0100, 3'b000, 1'b0, 2'b01, 4'b0110, 5'd0);
        step();
        chk("b.vs taken", out_br_taken, 1'b1);

        // SUBS 5-5, then B.EQ and B.HI
        beat(64'd0, 4'b0110, 3'b011, 1'b1, 2'b00, 4'd0, 5'd2);
        step();
        chk("subs flags", flags_q, 4'b0110);
        beat(64'd0, 4'b0000, 3'b000, 1'b0, 2'b01, 4'b0000, 5'd0);
        step();
        chk("b.eq taken", out_br_taken, 1'b1);
        beat(64'd0, 4'b0000, 3'b000, 1'b0, 2'b01, 4'b1000, 5'd0);
        step();
        chk("b.hi taken", out_br_taken, 1'b0);

        // ANDS clears C/V; ORR with set_flags leaves flags alone
        beat(64'd0, 4'b0111, 3'b100, 1'b1, 2'b00, 4'd0, 5'd3);
        step();
        chk("ands flags", flags_q, 4'b0100);
        beat(64'hFF, 4'b1011, 3'b101, 1'b1, 2'b00, 4'd0, 5'd4);
        step();
        chk("orr flags", flags_q, 4'b0100);

        // CBZ / CBNZ / no-branch with AL
        beat(64'd0, 4'b0100, 3'b000, 1'b0, 2'b10, 4'd0, 5'd0);
        step();
        chk("cbz taken", out_br_taken, 1'b1);
        beat(64'd0, 4'b0100, 3'b000, 1'b0, 2'b11, 4'd0, 5'd0);
        step();
        chk("cbnz taken", out_br_taken, 1'b0);
        beat(64'd7, 4'b0100, 3'b000, 1'b0, 2'b00, 4'b1110, 5'd5);
        step();
        chk("none taken", out_br_taken, 1'b0);
        idle();
        step();

        // Backpressure: rd 1,2,3 with out_ready low
        out_ready = 1'b0;
        beat(64'h11, 4'b0000, 3'b010, 1'b0, 2'b00, 4'd0, 5'd1);
        step();
        chk("bp in_ready after 1", in_ready, 1'b1);
        beat(64'h22, 4'b0000, 3'b010, 1'b0, 2'b00, 4'd0, 5'd2);
        step();
        chk("bp in_ready after 2", in_ready, 1'b0);
        chk("bp rd held", out_rd, 5'd1);
        beat(64'h33, 4'b0000, 3'b010, 1'b0, 2'b00, 4'd0, 5'd3);
        step();
        chk("bp in_ready stall", in_ready, 1'b0);
        chk("bp rd stable", out_rd, 5'd1);
        out_ready = 1'b1;
        step();
        chk("bp rd 2", out_rd, 5'd2);
        step();
        chk("bp rd 3", out_rd, 5'd3);
        idle();
        step();
        chk("bp drained", out_valid, 1'b0);

        // Async reset while FULL with all flags set
        out_ready = 1'b0;
        beat(64'h44, 4'b1111, 3'b010, 1'b1, 2'b00, 4'd0, 5'd4);
        step();
        beat(64'h55, 4'b0000, 3'b000, 1'b0, 2'b00, 4'd0, 5'd5);
        step();
        chk("full flags", flags_q, 4'b1111);
        chk("full in_ready", in_ready, 1'b0);
        idle();
        #1 reset_n = 1'b0;
        #1;
        chk("mid rst out_valid", out_valid, 1'b0);
        chk("mid rst flags", flags_q, 4'b0000);
        chk("mid rst in_ready", in_ready, 1'b1);
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        beat(64'h66, 4'b0000, 3'b000, 1'b0, 2'b00, 4'd0, 5'd6);
        step();
        chk("post rst valid", out_valid, 1'b1);
        chk("post rst rd", out_rd, 5'd6);
        idle();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
Execute-stage back end that sits directly downstream of the 64-bit ALU. It captures the ALU result and flags into a valid/ready pipeline register with a skid slot. It maintains the architectural NZCV flag register for flag-setting ops (ADDS/SUBS/ANDS). It resolves B.cond, CBZ and CBNZ outcomes for the next stage (memory/writeback, branch redirect).

Parameters:
WIDTH, 64, datapath width (result, ALU operands)
RADDR_W, 5, destination register index width

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
alu_result  in  WIDTH  ALU result
alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags
alu_cntrl  in  3  ALU op of this beat (000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR)
set_flags  in  1  instruction is ADDS/SUBS/ANDS
br_kind  in  2  00 none, 01 B.cond, 10 CBZ, 11 CBNZ
cond  in  4  condition code for B.cond
rd  in  RADDR_W  destination register
wr_en  in  1  instruction writes rd
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts
out_result  out  WIDTH  registered result
out_rd  out  RADDR_W  registered rd
out_wr_en  out  1  registered wr_en
out_br_taken  out  1  branch resolved taken (0 when br_kind=00)
flags_q  out  4  architectural flags {N,Z,C,V}

Behaviour:
- Reset (reset_n low, async): out_valid=0, out_result=0, out_rd=0, out_wr_en=0, out_br_taken=0, flags_q=0, skid slot empty. in_ready is 1 but no transfer occurs while reset_n is low. Reset mid-stream drops all held beats; there is no replay.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Structure: 2-entry elastic buffer (main register + skid). in_ready = !skid_valid, so in_ready is driven from a register. Latency is 1 cycle from accept to out_valid when the buffer is empty. Strict in-order delivery.
- Buffer states:
  - EMPTY: accept goes to main; next state ONE.
  - ONE: accept & emit loads main with the new beat. Accept & !emit puts the beat in skid; next state FULL. Emit alone goes to EMPTY.
  - FULL: in_ready=0. On emit, skid moves to main; next state ONE.
- Flag update happens at accept, not at emit. Flags update only when set_flags=1:
  - ADD/SUB: flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}.
  - AND: flags_q <= {alu_negative, alu_zero, 0, 0}.
  - Any other alu_cntrl: flags_q unchanged.
- Branch resolution also happens at accept and is stored alongside the beat:
  - B.cond uses flags_q as it stands before this beat's own update, i.e. the flags of the last accepted flag-setter.
  - Back-to-back SUBS then B.cond on consecutive accept cycles therefore sees the SUBS flags.
  - CBZ: taken = alu_zero (ALU runs PASS_B on Rt). CBNZ: taken = !alu_zero.
- Condition table:
  - EQ 0000: Z. NE 0001: !Z. HS 0010: C. LO 0011: !C.
  - MI 0100: N. PL 0101: !N. VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !(C&!Z).
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: !(!Z&(N==V)).
  - AL 1110 / NV 1111: 1.
- Outputs are held stable while out_valid & !out_ready.

Decomposition:
- Package alu_pkg holds:
  - cntrl constants ALU_PASS_B/ADD/SUBTRACT/AND/OR/XOR;
  - cond_e enum (EQ..NV);
  - br_kind_e;
  - flags_t packed struct {n,z,c,v};
  - function cond_eval(flags_t, cond_e).
- One natural sub-module: skid_buffer, parameterised on payload width, carrying {result, rd, wr_en, br_taken}.

Test Plan:
- ADDS alu_result=0x8000_0000_0000_0000, N=1, Z=0, C=0, V=1, then B.cond GE and B.cond VS on the next two cycles -> flags_q=4'b1001; both out_br_taken=1, out_valid one cycle after each accept.
- SUBS 5-5 (Z=1, C=1, result 0), then B.EQ, then B.HI -> flags_q=4'b0110; EQ taken=1, HI taken=0.
- ANDS with alu_carry_out=1, alu_overflow=1, result 0 -> flags_q=4'b0100 (C, V cleared). Then ORR with set_flags=1 -> flags_q stays 4'b0100.
- Backpressure: out_ready=0, three consecutive beats with rd=1,2,3 -> in_ready falls after beat 2, beat 3 is held upstream. Raise out_ready -> beats emerge rd=1,2,3 on consecutive cycles, none lost or duplicated.
- CBZ with alu_zero=1 -> taken=1; CBNZ with alu_zero=1 -> taken=0; br_kind=00 -> out_br_taken=0 regardless of cond.
- Assert reset_n low asynchronously mid-cycle while FULL with flags_q=4'b1111 -> out_valid=0 and flags_q=0 immediately; in_ready=1. The first beat after release appears after 1-cycle latency.
